// File: rtl/mdu_issue_ctrl.sv
// Issue/handshake controller in front of the RV32M multiply/divide unit.
// Optional 1-entry result cache enabled by defining MDU_RESULT_REUSE_EN.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_mode,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [31:0] mdu_num1,
    output logic [31:0] mdu_num2,
    output logic [7:0]  mdu_mode,
    input  logic [31:0] mdu_ans,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             stall_q, stall_d;
    logic [31:0]      mdu_num1_q, mdu_num1_d, mdu_num2_q, mdu_num2_d;
    logic [7:0]       mdu_mode_q, mdu_mode_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [4:0]       resp_rd_q, resp_rd_d;
    logic             resp_err_q, resp_err_d;

    logic        accept, mode_ok, unsup, div_zero, ovf, is_rem, run_last;
    logic        cache_hit;
    logic [31:0] cache_data;

    // Op classification on the raw request; bit 2 = divide group, bit 1 = remainder.
    assign accept   = req_valid && req_ready_q && !flush && (state_q == IDLE);
    assign mode_ok  = (req_mode[7:3] == 5'b01000);
    assign unsup    = !mode_ok || (req_mode[2:0] == 3'd2);
    assign is_rem   = req_mode[1];
    assign div_zero = mode_ok && req_mode[2] && (req_rs2 == 32'd0);
    assign ovf      = mode_ok && req_mode[2] && !req_mode[0]
                      && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    assign run_last = (cnt_q <= CNT_W'(1));

`ifdef MDU_RESULT_REUSE_EN
    logic        cache_vld_q, cache_vld_d;
    logic [7:0]  cache_mode_q, cache_mode_d;
    logic [31:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
    logic [31:0] cache_res_q, cache_res_d;

    assign cache_hit  = cache_vld_q && (cache_mode_q == req_mode)
                        && (cache_rs1_q == req_rs1) && (cache_rs2_q == req_rs2);
    assign cache_data = cache_res_q;

    // Refill only from ops that actually completed through the MDU.
    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_mode_d = cache_mode_q;
        cache_rs1_d  = cache_rs1_q;
        cache_rs2_d  = cache_rs2_q;
        cache_res_d  = cache_res_q;
        if (flush) begin
            cache_vld_d = 1'b0;
        end else if (state_q == RUN && run_last) begin
            cache_vld_d  = 1'b1;
            cache_mode_d = mdu_mode_q;
            cache_rs1_d  = mdu_num1_q;
            cache_rs2_d  = mdu_num2_q;
            cache_res_d  = mdu_ans;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q  <= 1'b0;
            cache_mode_q <= 8'h00;
            cache_rs1_q  <= 32'd0;
            cache_rs2_q  <= 32'd0;
            cache_res_q  <= 32'd0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_mode_q <= cache_mode_d;
            cache_rs1_q  <= cache_rs1_d;
            cache_rs2_q  <= cache_rs2_d;
            cache_res_q  <= cache_res_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 32'd0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mdu_num1_d   = mdu_num1_q;
        mdu_num2_d   = mdu_num2_q;
        mdu_mode_d   = 8'h00;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resp_rd_d    = req_rd;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                    if (unsup) begin
                        resp_data_d = 32'd0;
                        resp_err_d  = 1'b1;
                    end else if (div_zero) begin
                        resp_data_d = is_rem ? req_rs1 : 32'hFFFF_FFFF;
                    end else if (ovf) begin
                        resp_data_d = is_rem ? 32'd0 : 32'h8000_0000;
                    end else if (cache_hit) begin
                        resp_data_d = cache_data;
                    end else begin
                        state_d      = RUN;
                        resp_valid_d = 1'b0;
                        cnt_d        = req_mode[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        mdu_num1_d   = req_rs1;
                        mdu_num2_d   = req_rs2;
                        mdu_mode_d   = req_mode;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (run_last) begin
                    state_d      = DONE;
                    cnt_d        = '0;
                    resp_data_d  = mdu_ans;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    mdu_mode_d = mdu_mode_q;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        stall_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            stall_q      <= 1'b0;
            mdu_num1_q   <= 32'd0;
            mdu_num2_q   <= 32'd0;
            mdu_mode_q   <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            stall_q      <= stall_d;
            mdu_num1_q   <= mdu_num1_d;
            mdu_num2_q   <= mdu_num2_d;
            mdu_mode_q   <= mdu_mode_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign stall      = stall_q;
    assign mdu_num1   = mdu_num1_q;
    assign mdu_num2   = mdu_num2_q;
    assign mdu_mode   = mdu_mode_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural combinational MDU.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, resp_err, stall;
    logic [7:0]  req_mode, mdu_mode;
    logic [31:0] req_rs1, req_rs2, mdu_num1, mdu_num2, mdu_ans, resp_data;
    logic [4:0]  req_rd, resp_rd;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.MUL_LAT(1), .DIV_LAT(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .mdu_num1(mdu_num1), .mdu_num2(mdu_num2), .mdu_mode(mdu_mode), .mdu_ans(mdu_ans),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err), .stall(stall)
    );

    // Reference MDU: combinational result for the registered mode/operands.
    function automatic logic [31:0] mdu_model(input logic [7:0] m, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        pu;
        logic signed [63:0] ps;
        pu = {32'd0, a} * {32'd0, b};
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (m)
            8'h40:   return pu[31:0];
            8'h41:   return ps[63:32];
            8'h43:   return pu[63:32];
            8'h44:   return (b == 32'd0) ? 32'd0 : 32'($signed(a) / $signed(b));
            8'h45:   return (b == 32'd0) ? 32'd0 : a / b;
            8'h46:   return (b == 32'd0) ? 32'd0 : 32'($signed(a) % $signed(b));
            8'h47:   return (b == 32'd0) ? 32'd0 : a % b;
            default: return 32'd0;
        endcase
    endfunction

    assign mdu_ans = mdu_model(mdu_mode, mdu_num1, mdu_num2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        req_mode  = m;
        req_rs1   = a;
        req_rs2   = b;
        req_rd    = rd;
        req_valid = 1'b1;
        check("req_ready_at_issue", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Latency in cycles from the accept cycle to resp_valid, bounded.
    task automatic wait_resp(output int l);
        l = 1;
        while (resp_valid !== 1'b1 && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_drop", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err);
        issue(m, a, b, rd);
        check({tag, "_stall"}, 32'(stall), 32'd1);
        if (exp_lat == 1) check({tag, "_mode_idle"}, 32'(mdu_mode), 32'd0);
        wait_resp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, resp_data, exp_data);
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_rd"}, 32'(resp_rd), 32'(rd));
        handshake();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_mode = 8'h00; req_rs1 = 32'd0; req_rs2 = 32'd0; req_rd = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mode", 32'(mdu_mode), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);

        // MUL through RUN: check the MDU is driven during RUN
        issue(8'h40, 32'd7, 32'd6, 5'd3);
        check("mul_run_mode", 32'(mdu_mode), 32'h40);
        check("mul_run_stall", 32'(stall), 32'd1);
        check("mul_run_valid", 32'(resp_valid), 32'd0);
        wait_resp(lat);
        check("mul_lat", 32'(lat), 32'd2);
        check("mul_data", resp_data, 32'd42);
        check("mul_err", 32'(resp_err), 32'd0);
        check("mul_done_stall", 32'(stall), 32'd1);
        check("mul_done_mode", 32'(mdu_mode), 32'd0);
        handshake();
        check("mul_idle_stall", 32'(stall), 32'd0);

        run_op("div0",   8'h44, 32'd100, 32'd0, 5'd4, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("remu0",  8'h47, 32'd100, 32'd0, 5'd5, 1, 32'd100, 1'b0);
        run_op("divovf", 8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 32'h8000_0000, 1'b0);
        run_op("removf", 8'h46, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 32'd0, 1'b0);
        run_op("mulhsu", 8'h42, 32'd3, 32'd4, 5'd8, 1, 32'd0, 1'b1);
        run_op("bad33",  8'h33, 32'd3, 32'd4, 5'd9, 1, 32'd0, 1'b1);
        run_op("mulh",   8'h41, 32'hFFFF_FFFF, 32'd2, 5'd10, 2, 32'hFFFF_FFFF, 1'b0);

        // Backpressure: result held while resp_ready is low
        issue(8'h45, 32'd20, 32'd3, 5'd11);
        wait_resp(lat);
        check("hold_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", resp_data, 32'd6);
            check("hold_rd", 32'(resp_rd), 32'd11);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_valid", 32'(resp_valid), 32'd1);
        end
        handshake();
        run_op("after_hold", 8'h40, 32'd3, 32'd5, 5'd12, 2, 32'd15, 1'b0);

        // Flush mid-RUN
        issue(8'h45, 32'd9, 32'd2, 5'd13);
        check("flush_in_run", 32'(mdu_mode), 32'h45);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", 32'(resp_valid), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_resp", 32'(resp_valid), 32'd0);
        end

        // Flush with req_valid in IDLE must not accept
        req_mode = 8'h40; req_rs1 = 32'd2; req_rs2 = 32'd2; req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_stall", 32'(stall), 32'd0);
        check("flush_idle_valid", 32'(resp_valid), 32'd0);

        // Back-to-back identical MULHU: second is a cache hit when reuse is built in
        run_op("mulhu_a", 8'h43, 32'hFFFF_FFFF, 32'd2, 5'd14, 2, 32'd1, 1'b0);
`ifdef MDU_RESULT_REUSE_EN
        run_op("mulhu_b", 8'h43, 32'hFFFF_FFFF, 32'd2, 5'd15, 1, 32'd1, 1'b0);
`else
        run_op("mulhu_b", 8'h43, 32'hFFFF_FFFF, 32'd2, 5'd15, 2, 32'd1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
